// File: rtl/lcd_pkg.sv
// Shared definitions for the ST7789 LCD path: word layout, writer FSM states
// and the command opcodes used by the init/draw sequencers.
package lcd_pkg;

  localparam int LCD_WORD_W = 9;
  localparam int DC_BIT     = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LATCH = 3'd1,
    ST_SHIFT = 3'd2,
    ST_DONE  = 3'd3,
    ST_GAP   = 3'd4
  } lcd_state_t;

  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_SLPOUT  = 8'h11;
  localparam logic [7:0] CMD_DISPON  = 8'h29;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_RASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;
  localparam logic [7:0] CMD_MADCTL  = 8'h36;
  localparam logic [7:0] CMD_COLMOD  = 8'h3A;

  function automatic logic [LCD_WORD_W-1:0] lcd_word(input logic is_data, input logic [7:0] value);
    return {is_data, value};
  endfunction

endpackage

// File: rtl/lcd_spi_writer_if.sv
// Sequencer-to-writer handshake plus the panel pins driven by the writer.
interface lcd_spi_writer_if;
  import lcd_pkg::*;

  logic                  en_write;
  logic [LCD_WORD_W-1:0] data;
  logic                  wr_done;
  logic                  busy;
  logic                  lcd_sclk;
  logic                  lcd_mosi;
  logic                  lcd_dc;
  logic                  lcd_cs;

  modport master (
    output en_write, data,
    input  wr_done, busy, lcd_sclk, lcd_mosi, lcd_dc, lcd_cs
  );

  modport slave (
    input  en_write, data,
    output wr_done, busy, lcd_sclk, lcd_mosi, lcd_dc, lcd_cs
  );

endinterface

// File: rtl/lcd_sclk_div.sv
// Half-period tick generator: tick is high on the last system cycle of each
// SCLK half-period while enabled.
module lcd_sclk_div #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_r;

  // half-period counter, stops at TERM and restarts
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
    end else if (enable) begin
      if (cnt_r == TERM) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1'b1);
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign tick = enable && (cnt_r == TERM);

endmodule

// File: rtl/lcd_spi_writer.sv
// 4-wire SPI byte transmitter for the ST7789 panel: shifts {dc, byte} out MSB
// first and pulses wr_done once per byte.
module lcd_spi_writer
  import lcd_pkg::*;
#(
  parameter int SCLK_DIV    = 2,
  parameter int GAP_CYCLES  = 3,
  parameter int CS_PER_BYTE = 1
) (
  input  logic              sys_clk_50MHz,
  input  logic              sys_rst,
  lcd_spi_writer_if.slave   bus
);

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_TERM = GAP_W'(GAP_CYCLES - 1);
  localparam bit CHAIN = (CS_PER_BYTE == 0) ? 1'b1 : 1'b0;

  lcd_state_t       state_r;
  logic [7:0]       shift_r;
  logic [2:0]       bit_cnt_r;
  logic [GAP_W-1:0] gap_cnt_r;
  logic             high_phase_r;
  logic             wr_done_r;
  logic             busy_r;
  logic             sclk_r;
  logic             mosi_r;
  logic             dc_r;
  logic             cs_r;
  logic             tick_s;
  logic             div_en_s;
  logic             div_clr_s;

  assign div_en_s  = (state_r == ST_SHIFT);
  assign div_clr_s = (state_r == ST_LATCH);

  lcd_sclk_div #(.DIV(SCLK_DIV)) u_sclk_div (
    .clk    (sys_clk_50MHz),
    .rst    (sys_rst),
    .enable (div_en_s),
    .clear  (div_clr_s),
    .tick   (tick_s)
  );

  // writer FSM with registered panel and handshake outputs
  always_ff @(posedge sys_clk_50MHz) begin
    if (sys_rst) begin
      state_r      <= ST_IDLE;
      shift_r      <= 8'h00;
      bit_cnt_r    <= 3'd0;
      gap_cnt_r    <= '0;
      high_phase_r <= 1'b0;
      wr_done_r    <= 1'b0;
      busy_r       <= 1'b0;
      sclk_r       <= 1'b1;
      mosi_r       <= 1'b0;
      dc_r         <= 1'b0;
      cs_r         <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          wr_done_r <= 1'b0;
          if (bus.en_write) begin
            state_r <= ST_LATCH;
          end else begin
            cs_r <= 1'b1;
          end
        end
        ST_LATCH: begin
          shift_r      <= bus.data[7:0];
          dc_r         <= bus.data[DC_BIT];
          mosi_r       <= bus.data[7];
          cs_r         <= 1'b0;
          busy_r       <= 1'b1;
          sclk_r       <= 1'b0;
          bit_cnt_r    <= 3'd7;
          high_phase_r <= 1'b0;
          state_r      <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (tick_s) begin
            if (!high_phase_r) begin
              sclk_r       <= 1'b1;
              high_phase_r <= 1'b1;
            end else if (bit_cnt_r == 3'd0) begin
              wr_done_r <= 1'b1;
              state_r   <= ST_DONE;
            end else begin
              // next bit goes out with the falling edge, so mosi never moves while sclk is high
              shift_r      <= {shift_r[6:0], 1'b0};
              mosi_r       <= shift_r[6];
              sclk_r       <= 1'b0;
              bit_cnt_r    <= bit_cnt_r - 3'd1;
              high_phase_r <= 1'b0;
            end
          end
        end
        ST_DONE: begin
          wr_done_r <= 1'b0;
          gap_cnt_r <= '0;
          if (!CHAIN || !bus.en_write) begin
            cs_r <= 1'b1;
          end
          state_r <= ST_GAP;
        end
        ST_GAP: begin
          if (gap_cnt_r == GAP_TERM) begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            gap_cnt_r <= gap_cnt_r + GAP_W'(1'b1);
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          wr_done_r <= 1'b0;
          busy_r    <= 1'b0;
          sclk_r    <= 1'b1;
          cs_r      <= 1'b1;
        end
      endcase
    end
  end

  assign bus.wr_done  = wr_done_r;
  assign bus.busy     = busy_r;
  assign bus.lcd_sclk = sclk_r;
  assign bus.lcd_mosi = mosi_r;
  assign bus.lcd_dc   = dc_r;
  assign bus.lcd_cs   = cs_r;

endmodule

// File: tb/tb_lcd_spi_writer.sv
// Bench for lcd_spi_writer: an SPI-slave model decodes the pins and is compared
// with the words a sequencer model sends; two instances cover both CS modes.
module tb_lcd_spi_writer;
  import lcd_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  lcd_spi_writer_if bus_a ();
  lcd_spi_writer_if bus_b ();

  lcd_spi_writer #(.SCLK_DIV(2), .GAP_CYCLES(3), .CS_PER_BYTE(1)) dut_a (
    .sys_clk_50MHz (clk),
    .sys_rst       (rst),
    .bus           (bus_a)
  );

  lcd_spi_writer #(.SCLK_DIV(1), .GAP_CYCLES(3), .CS_PER_BYTE(0)) dut_b (
    .sys_clk_50MHz (clk),
    .sys_rst       (rst),
    .bus           (bus_b)
  );

  logic [1:0] en = 2'b00;
  logic [8:0] din [2];
  logic [1:0] busy_w, done_w, sclk_w, mosi_w, dc_w, cs_w;

  assign bus_a.en_write = en[0];
  assign bus_b.en_write = en[1];
  assign bus_a.data     = din[0];
  assign bus_b.data     = din[1];
  assign busy_w = {bus_b.busy,     bus_a.busy};
  assign done_w = {bus_b.wr_done,  bus_a.wr_done};
  assign sclk_w = {bus_b.lcd_sclk, bus_a.lcd_sclk};
  assign mosi_w = {bus_b.lcd_mosi, bus_a.lcd_mosi};
  assign dc_w   = {bus_b.lcd_dc,   bus_a.lcd_dc};
  assign cs_w   = {bus_b.lcd_cs,   bus_a.lcd_cs};

  int n_checks = 0;
  int n_fail   = 0;

  // panel-side model state, per instance
  logic [1:0] psclk = 2'b11, pmosi = 2'b00, pdc = 2'b00, pcs = 2'b11, seen_low = 2'b00;
  logic [7:0] bits    [2] = '{8'h00, 8'h00};
  logic [8:0] rx_word [2] = '{9'h000, 9'h000};
  int nbits     [2] = '{0, 0};
  int rx_cnt    [2] = '{0, 0};
  int viol      [2] = '{0, 0};
  int done_cnt  [2] = '{0, 0};
  int exp_done  [2] = '{0, 0};
  int cs_rise   [2] = '{0, 0};
  int cs_hi_run [2] = '{0, 0};
  int min_gap   [2] = '{1000, 1000};
  logic [8:0] wq [$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // SPI slave: capture mosi on each sclk rise while cs is low, plus pin rules
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      psclk[d] <= sclk_w[d];
      pmosi[d] <= mosi_w[d];
      pdc[d]   <= dc_w[d];
      pcs[d]   <= cs_w[d];
      if (rst) begin
        nbits[d] <= 0;
      end else if (sclk_w[d] && !psclk[d] && !cs_w[d]) begin
        bits[d] <= {bits[d][6:0], mosi_w[d]};
        if (nbits[d] == 7) begin
          rx_word[d] <= {dc_w[d], bits[d][6:0], mosi_w[d]};
          rx_cnt[d]  <= rx_cnt[d] + 1;
          nbits[d]   <= 0;
        end else begin
          nbits[d] <= nbits[d] + 1;
        end
      end
      if (!rst && sclk_w[d] && psclk[d] && (mosi_w[d] != pmosi[d] || dc_w[d] != pdc[d]))
        viol[d] <= viol[d] + 1;
      if (done_w[d]) done_cnt[d] <= done_cnt[d] + 1;
      if (cs_w[d] && !pcs[d]) cs_rise[d] <= cs_rise[d] + 1;
      if (cs_w[d]) begin
        cs_hi_run[d] <= cs_hi_run[d] + 1;
      end else begin
        if (pcs[d] && seen_low[d] && cs_hi_run[d] < min_gap[d]) min_gap[d] <= cs_hi_run[d];
        cs_hi_run[d] <= 0;
        seen_low[d]  <= 1'b1;
      end
    end
  end

  // sequencer model: holds en_write, updates data 2 cycles after each wr_done
  task automatic run_seq(input int d, input int drop_at);
    int t;
    int lat;
    int rx0;
    int div_v;
    div_v = (d == 0) ? 2 : 1;
    @(posedge clk); #1;
    en[d]  = 1'b1;
    din[d] = wq[0];
    for (int i = 0; i < wq.size(); i++) begin
      t = 0;
      while (busy_w[d] && t < 200) begin @(negedge clk); t++; end
      t = 0;
      while (!busy_w[d] && t < 200) begin @(negedge clk); t++; end
      check_val("busy_rise", {31'd0, busy_w[d]}, 32'd1);
      rx0 = rx_cnt[d];
      lat = 0;
      while (!done_w[d] && lat < 200) begin
        @(negedge clk);
        lat++;
        if (lat == drop_at) en[d] = 1'b0;
      end
      exp_done[d]++;
      check_val("latency", lat, 16 * div_v);
      check_val("rx_word", {23'd0, rx_word[d]}, {23'd0, wq[i]});
      check_val("rx_count", rx_cnt[d] - rx0, 32'd1);
      check_val("bit_edges", nbits[d], 32'd0);
      @(negedge clk);
      check_val("wr_done_pulse", {31'd0, done_w[d]}, 32'd0);
      check_val("cs_after_done", {31'd0, cs_w[d]}, (d == 0) ? 32'd1 : 32'd0);
      @(posedge clk); #1;
      if (i + 1 < wq.size()) din[d] = wq[i + 1];
      else en[d] = 1'b0;
    end
    t = 0;
    while (busy_w[d] && t < 50) begin @(negedge clk); t++; end
    @(negedge clk);
    check_val("idle_busy", {31'd0, busy_w[d]}, 32'd0);
    check_val("idle_cs", {31'd0, cs_w[d]}, 32'd1);
    repeat (6) @(negedge clk);
    check_val("no_resend", {31'd0, busy_w[d]}, 32'd0);
  endtask

  initial begin
    din[0] = 9'h000;
    din[1] = 9'h000;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check_val("rst_wr_done", {31'd0, done_w[d]}, 32'd0);
      check_val("rst_busy",    {31'd0, busy_w[d]}, 32'd0);
      check_val("rst_sclk",    {31'd0, sclk_w[d]}, 32'd1);
      check_val("rst_mosi",    {31'd0, mosi_w[d]}, 32'd0);
      check_val("rst_dc",      {31'd0, dc_w[d]},   32'd0);
      check_val("rst_cs",      {31'd0, cs_w[d]},   32'd1);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);

    wq = '{9'h011};               run_seq(0, -1);
    wq = '{9'h1A5};               run_seq(0, -1);
    wq = '{9'h011, 9'h036, 9'h100}; run_seq(0, -1);
    wq = '{9'h0B2};               run_seq(0, 17);

    // reset in the middle of a byte
    @(posedge clk); #1;
    en[0]  = 1'b1;
    din[0] = lcd_word(1'b0, 8'hE7);
    begin
      int t;
      t = 0;
      while (!busy_w[0] && t < 50) begin @(negedge clk); t++; end
    end
    repeat (10) @(negedge clk);
    rst   = 1'b1;
    en[0] = 1'b0;
    @(negedge clk);
    check_val("abort_sclk",    {31'd0, sclk_w[0]}, 32'd1);
    check_val("abort_cs",      {31'd0, cs_w[0]},   32'd1);
    check_val("abort_mosi",    {31'd0, mosi_w[0]}, 32'd0);
    check_val("abort_wr_done", {31'd0, done_w[0]}, 32'd0);
    check_val("abort_busy",    {31'd0, busy_w[0]}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    wq = '{9'h02C};               run_seq(0, -1);

    wq = {};
    for (int i = 0; i < 5; i++) wq.push_back(9'($urandom_range(0, 511)));
    run_seq(0, -1);

    wq = '{9'($urandom_range(0, 511)), 9'($urandom_range(0, 511))};
    run_seq(1, -1);

    repeat (2) @(negedge clk);
    check_val("done_count_a", done_cnt[0], exp_done[0]);
    check_val("done_count_b", done_cnt[1], exp_done[1]);
    check_val("stable_high_a", viol[0], 32'd0);
    check_val("stable_high_b", viol[1], 32'd0);
    check_val("cs_gap_min3", {31'd0, (min_gap[0] >= 3)}, 32'd1);
    check_val("cs_chain_rises", cs_rise[1], 32'd1);
    check_val("partial_bits", nbits[0], 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
